// File: rtl/music_box_sequencer.sv
// rtl/music_box_sequencer.sv - tempo-programmable 0..15 step index generator for the note-pattern lookup
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        1-cycle pulse, (re)start song at index 0
//   stop         1-cycle pulse, abort to IDLE
//   pause        level, hold current step while PLAYING
//   loop_en      level, wrap 15->0 instead of finishing
//   tempo_sel    step period = TICKS_PER_STEP << tempo_sel
//   w,x,y,z      step index bits 3..0
//   note_en      high only while PLAYING
//   step_strobe  pulse on first cycle of each new step
//   song_done    pulse on entry to DONE
//   state        IDLE=0, PLAYING=1, PAUSED=2, DONE=3
module music_box_sequencer #(
  parameter int TICKS_PER_STEP = 4,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop_en,
  input  logic [1:0] tempo_sel,
  output logic       w,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       note_en,
  output logic       step_strobe,
  output logic       song_done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           st;
  logic [3:0]       index;
  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] period_sel;
  logic             step_end;

  // Only sampled into the period latch at start or a step boundary, so a
  // tempo change never stretches or truncates the step in progress.
  assign period_sel = CNT_W'(TICKS_PER_STEP) << tempo_sel;
  assign step_end   = (tick_cnt == period - CNT_W'(1));

  // Outputs come straight from state registers.
  assign {w, x, y, z} = index;
  assign state        = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      index       <= 4'd0;
      tick_cnt    <= '0;
      period      <= CNT_W'(TICKS_PER_STEP);
      note_en     <= 1'b0;
      step_strobe <= 1'b0;
      song_done   <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      song_done   <= 1'b0;
      if (stop) begin
        st       <= IDLE;
        index    <= 4'd0;
        tick_cnt <= '0;
        note_en  <= 1'b0;
      end else if (start) begin
        st          <= PLAYING;
        index       <= 4'd0;
        tick_cnt    <= '0;
        period      <= period_sel;
        note_en     <= 1'b1;
        step_strobe <= 1'b1;
      end else begin
        case (st)
          PLAYING: begin
            // The boundary check comes before pause so a step that is due
            // always advances; pause then lands on the following cycle.
            if (step_end) begin
              tick_cnt <= '0;
              period   <= period_sel;
              if (index != 4'd15 || loop_en) begin
                index       <= index + 4'd1;   // 15 + 1 wraps to 0 when looping
                step_strobe <= 1'b1;
              end else begin
                st        <= DONE;
                note_en   <= 1'b0;
                song_done <= 1'b1;
              end
            end else if (pause) begin
              st      <= PAUSED;
              note_en <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
          PAUSED: begin
            // tick_cnt stays frozen, so the remaining step time is kept.
            if (!pause) begin
              st      <= PLAYING;
              note_en <= 1'b1;
            end
          end
          default: begin
            // IDLE and DONE hold until start or stop.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_music_box_sequencer.sv
// tb/tb_music_box_sequencer.sv - scoreboard bench for music_box_sequencer
module tb_music_box_sequencer;

  localparam int TPS = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       pause;
  logic       loop_en;
  logic [1:0] tempo_sel;
  logic       w, x, y, z;
  logic       note_en;
  logic       step_strobe;
  logic       song_done;
  logic [1:0] state;
  logic [8:0] outs;

  music_box_sequencer #(
    .TICKS_PER_STEP(TPS),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .pause(pause),
    .loop_en(loop_en),
    .tempo_sel(tempo_sel),
    .w(w),
    .x(x),
    .y(y),
    .z(z),
    .note_en(note_en),
    .step_strobe(step_strobe),
    .song_done(song_done),
    .state(state)
  );

  assign outs = {state, w, x, y, z, note_en, step_strobe, song_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
  endtask

  task automatic check_int(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
  endtask

  // Reference model: song described as flags plus a countdown of cycles
  // remaining in the current step.
  bit m_play, m_hold, m_fin, m_strobe, m_done;
  int m_pos  = 0;
  int m_len  = TPS;
  int m_left = TPS;

  function automatic int period_for(input logic [1:0] t);
    return TPS * (1 << int'(t));
  endfunction

  task automatic model_step();
    m_strobe = 0;
    m_done   = 0;
    if (!rst_n) begin
      m_play = 0; m_hold = 0; m_fin = 0; m_pos = 0; m_len = TPS; m_left = TPS;
    end else if (stop) begin
      m_play = 0; m_hold = 0; m_fin = 0; m_pos = 0;
    end else if (start) begin
      m_play = 1; m_hold = 0; m_fin = 0; m_pos = 0;
      m_len = period_for(tempo_sel); m_left = m_len; m_strobe = 1;
    end else if (m_play) begin
      if (m_left == 1) begin
        m_len = period_for(tempo_sel); m_left = m_len;
        if (m_pos < 15) begin
          m_pos++; m_strobe = 1;
        end else if (loop_en) begin
          m_pos = 0; m_strobe = 1;
        end else begin
          m_play = 0; m_fin = 1; m_done = 1;
        end
      end else if (pause) begin
        m_play = 0; m_hold = 1;
      end else begin
        m_left--;
      end
    end else if (m_hold && !pause) begin
      m_hold = 0; m_play = 1;
    end
  endtask

  function automatic logic [8:0] model_out();
    logic [1:0] sc;
    logic [3:0] pos;
    sc  = m_play ? 2'd1 : m_hold ? 2'd2 : m_fin ? 2'd3 : 2'd0;
    pos = 4'(m_pos);
    return {sc, pos, m_play, m_strobe, m_done};
  endfunction

  // Producer: one expected output word per rising edge.
  initial forever begin
    @(posedge clk);
    model_step();
    exp_q.push_back(model_out());
  end

  // Monitor: registered outputs are presented every cycle; compare on the falling edge.
  initial forever begin
    @(negedge clk);
    if (exp_q.size() == 0) check("queue_empty", outs, 9'h1ff);
    else check("cycle", outs, exp_q.pop_front());
  end

  task automatic drive(input bit s, input bit p, input bit pa, input bit lp, input logic [1:0] t);
    @(negedge clk);
    start = s; stop = p; pause = pa; loop_en = lp; tempo_sel = t;
  endtask

  task automatic idle(input int n, input bit pa, input bit lp, input logic [1:0] t);
    for (int i = 0; i < n; i++) drive(0, 0, pa, lp, t);
  endtask

  task automatic async_reset();
    @(negedge clk);
    start = 0; stop = 0;
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs, 9'h000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int n, s;
  bit rpa, rlp;
  logic [1:0] rt;

  initial begin
    rst_n = 1'b0; start = 0; stop = 0; pause = 0; loop_en = 0; tempo_sel = 2'd0;
    @(negedge clk);
    check("reset_state", outs, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3, 1, 1, 0);

    // Normal play: 64 cycles to song_done, 16 strobes.
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    n = 0;
    s = int'(step_strobe);
    while (!song_done && n < 200) begin
      @(negedge clk);
      n++;
      s += int'(step_strobe);
    end
    check_int("done_latency", n, 64);
    check_int("strobe_count", s, 16);
    check_int("done_state", int'(state), 3);
    idle(5, 1, 1, 0);

    // Tempo: start at tempo 2, switch to 0 mid step 3.
    drive(1, 0, 0, 0, 2);
    idle(3 * 16 + 5, 0, 0, 2);
    idle(40, 0, 0, 0);

    // Pause for 10 cycles at tick 1 of step 5, then measure time to step 6.
    drive(1, 0, 0, 0, 0);
    idle(21, 0, 0, 0);
    idle(10, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    n = 0;
    while (!step_strobe && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_int("resume_to_step", n, 3);
    check_int("resume_index", int'({w, x, y, z}), 6);
    idle(5, 0, 0, 0);

    // Loop through the wrap.
    drive(1, 0, 0, 1, 0);
    idle(80, 0, 1, 0);

    // Priority: start+stop together, then start while paused at index 9.
    drive(1, 1, 0, 0, 0);
    idle(3, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    idle(37, 0, 0, 0);
    idle(4, 1, 0, 0);
    drive(1, 0, 1, 0, 0);
    idle(6, 0, 0, 0);

    // Async reset at index 7, then remain idle until start.
    drive(1, 0, 0, 0, 0);
    idle(30, 0, 0, 0);
    async_reset();
    idle(10, 1, 1, 1);
    drive(1, 0, 0, 0, 1);
    idle(10, 0, 0, 1);

    // Randomized traffic.
    rpa = 0; rlp = 0; rt = 2'd0;
    for (int i = 0; i < 2500; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if ($urandom_range(0, 15) == 0) rpa = ~rpa;
      if ($urandom_range(0, 63) == 0) rlp = ~rlp;
      if ($urandom_range(0, 19) == 0) rt = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) async_reset();
      else drive(r < 25, r >= 25 && r < 33, rpa, rlp, rt);
    end

    idle(3, 0, 0, 0);
    #1 check_int("queue_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
